// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment display driver.
package seg_pkg;

  typedef enum logic [1:0] {
    SLOT_TENS   = 2'd0,
    SLOT_ONES   = 2'd1,
    SLOT_TENTHS = 2'd2
  } slot_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic slot_e slot_next(input slot_e s);
    case (s)
      SLOT_TENS: return SLOT_ONES;
      SLOT_ONES: return SLOT_TENTHS;
      default:   return SLOT_TENS;
    endcase
  endfunction

  // Active-low digit enable for the slot; [2]=tens, [1]=ones, [0]=tenths.
  function automatic logic [2:0] slot_dig_n(input slot_e s);
    case (s)
      SLOT_TENS:   return 3'b011;
      SLOT_ONES:   return 3'b101;
      SLOT_TENTHS: return 3'b110;
      default:     return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to seven-segment decoder; codes above 9 render as a dash.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed common-cathode display scanner with per-frame input snapshot,
// ghost-blanking gap, leading-zero blanking and warning blink.
//
// state        | meaning
// SLOT_TENS    | tens digit slot; snapshot taken at its first cycle
// SLOT_ONES    | ones digit slot; carries the decimal point in tenths mode
// SLOT_TENTHS  | tenths digit slot; lit only in tenths mode
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  input  logic [3:0] tenths_i,
  input  logic       point_i,
  input  logic       blink_i,
  output logic [2:0] dig_n,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  slot_e            slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             blink_phase_q, blink_phase_d;
  logic [3:0]       snap_tens_q, snap_tens_d;
  logic [3:0]       snap_ones_q, snap_ones_d;
  logic [3:0]       snap_tenths_q, snap_tenths_d;
  logic             snap_point_q, snap_point_d;
  logic             snap_blink_q, snap_blink_d;
  logic [2:0]       dig_n_q, dig_n_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic             snap_now;
  logic             suppress;
  logic [3:0]       digit_val;
  logic [6:0]       digit_seg;

  bcd_to_seg7 u_dec (
    .bcd_i (digit_val),
    .seg_o (digit_seg)
  );

  always_comb begin
    slot_d        = slot_q;
    cnt_d         = cnt_q;
    frm_d         = frm_q;
    blink_phase_d = blink_phase_q;
    snap_tens_d   = snap_tens_q;
    snap_ones_d   = snap_ones_q;
    snap_tenths_d = snap_tenths_q;
    snap_point_d  = snap_point_q;
    snap_blink_d  = snap_blink_q;
    dig_n_d       = 3'b111;
    seg_d         = SEG_OFF;
    dp_d          = 1'b0;
    digit_val     = snap_tens_q;
    suppress      = 1'b0;

    snap_now      = (slot_q == SLOT_TENS) && (cnt_q == '0);
    frame_start_d = snap_now;

    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = slot_next(slot_q);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (snap_now) begin
      snap_tens_d   = tens_i;
      snap_ones_d   = ones_i;
      snap_tenths_d = tenths_i;
      snap_point_d  = point_i;
      snap_blink_d  = blink_i;
      if (frm_q == FRM_LAST) begin
        frm_d         = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    case (slot_q)
      SLOT_TENS: begin
        digit_val = snap_tens_q;
        suppress  = (LZ_BLANK != 0) && (snap_tens_q == 4'd0);
      end
      SLOT_ONES: begin
        digit_val = snap_ones_q;
      end
      SLOT_TENTHS: begin
        digit_val = snap_tenths_q;
        suppress  = !snap_point_q;
      end
      default: suppress = 1'b1;
    endcase
    if (snap_blink_q && blink_phase_q) suppress = 1'b1;

    // The snapshot at cnt=0 always lands in the blank gap, so the ON phase never sees stale data.
    if ((cnt_q >= CNT_BLANK) && !suppress) begin
      dig_n_d = slot_dig_n(slot_q);
      seg_d   = digit_seg;
      dp_d    = (slot_q == SLOT_ONES) && snap_point_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q        <= SLOT_TENS;
      cnt_q         <= '0;
      frm_q         <= '0;
      blink_phase_q <= 1'b0;
      snap_tens_q   <= '0;
      snap_ones_q   <= '0;
      snap_tenths_q <= '0;
      snap_point_q  <= 1'b0;
      snap_blink_q  <= 1'b0;
      dig_n_q       <= 3'b111;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      frm_q         <= frm_d;
      blink_phase_q <= blink_phase_d;
      snap_tens_q   <= snap_tens_d;
      snap_ones_q   <= snap_ones_d;
      snap_tenths_q <= snap_tenths_d;
      snap_point_q  <= snap_point_d;
      snap_blink_q  <= snap_blink_d;
      dig_n_q       <= dig_n_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dig_n       = dig_n_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a frame-arithmetic reference model checked every cycle.
module tb_seg_scan_driver;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int LZ    = 1;
  localparam int FRAME = 3 * SCAN;

  logic       clk;
  logic       rst_n;
  logic [3:0] tens, ones, tenths;
  logic       point, blink;
  logic [2:0] dig_n;
  logic [6:0] seg;
  logic       dp, frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  seg_scan_driver #(
    .SCAN_DIV     (SCAN),
    .BLANK_CYC    (BLANK),
    .BLINK_FRAMES (BF),
    .LZ_BLANK     (LZ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tens_i      (tens),
    .ones_i      (ones),
    .tenths_i    (tenths),
    .point_i     (point),
    .blink_i     (blink),
    .dig_n       (dig_n),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: p counts clock edges since reset release; position in the frame
  // follows from plain division, the snapshot is latched at frame position 0.
  int         p = 0;
  bit         mv = 0;
  logic [3:0] m_tens, m_ones, m_tenths;
  logic       m_point, m_blink;
  logic [2:0] e_dig;
  logic [6:0] e_seg;
  logic       e_dp, e_fs;

  always @(posedge clk) begin
    int pos, s, c, f;
    bit phase, lit;
    logic [3:0] d;
    if (!rst_n) begin
      p = 0; mv = 1;
      e_dig = 3'b111; e_seg = 7'h00; e_dp = 1'b0; e_fs = 1'b0;
      m_tens = '0; m_ones = '0; m_tenths = '0; m_point = 1'b0; m_blink = 1'b0;
    end else begin
      pos = p % FRAME;
      s   = pos / SCAN;
      c   = pos % SCAN;
      f   = p / FRAME;
      if (pos == 0) begin
        m_tens = tens; m_ones = ones; m_tenths = tenths; m_point = point; m_blink = blink;
      end
      phase = (((f + 1) / BF) % 2) == 1;
      d = (s == 0) ? m_tens : (s == 1) ? m_ones : m_tenths;
      lit = (c >= BLANK) && !(s == 0 && LZ == 1 && m_tens == 4'd0)
            && !(s == 2 && !m_point) && !(m_blink && phase);
      e_dig = lit ? ~(3'b100 >> s) : 3'b111;
      e_seg = lit ? dec(d) : 7'h00;
      e_dp  = lit && (s == 1) && m_point;
      e_fs  = (pos == 0);
      p++;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("model_dig_n", {29'd0, dig_n}, {29'd0, e_dig});
      chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
      chk("model_dp", {31'd0, dp}, {31'd0, e_dp});
      chk("model_frame_start", {31'd0, frame_start}, {31'd0, e_fs});
      n_assert++;
      if ($countones(~dig_n) > 1) begin
        n_fail++;
        $display("FAIL onehot0: dig_n=%b has more than one digit enabled", dig_n);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the outputs reflect frame position tgt.
  task automatic wait_pos(input int tgt);
    bit hit;
    hit = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (rst_n && p > 0 && ((p - 1) % FRAME) == tgt) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  int lit_frames;

  initial begin
    rst_n = 1'b0;
    tens = 4'd1; ones = 4'd9; tenths = 4'd0; point = 1'b0; blink = 1'b0;
    repeat (3) step();
    chk("reset_dig_n", {29'd0, dig_n}, 32'h7);
    chk("reset_seg", {25'd0, seg}, 32'h0);
    chk("reset_fs", {31'd0, frame_start}, 32'h0);
    rst_n = 1'b1;

    wait_pos(0);
    chk("f0_frame_start", {31'd0, frame_start}, 32'h1);
    wait_pos(1);
    chk("f0_blank_gap", {29'd0, dig_n}, 32'h7);
    wait_pos(2);
    chk("f0_tens_dig", {29'd0, dig_n}, 32'h3);
    chk("f0_tens_seg", {25'd0, seg}, 32'h06);
    wait_pos(10);
    chk("f0_ones_seg", {25'd0, seg}, 32'h6F);
    chk("f0_ones_dp", {31'd0, dp}, 32'h0);
    wait_pos(18);
    chk("f0_tenths_off", {29'd0, dig_n}, 32'h7);

    tens = 4'd0; ones = 4'd5; tenths = 4'd3; point = 1'b1;
    wait_pos(0);
    wait_pos(2);
    chk("lz_tens_blank", {29'd0, dig_n}, 32'h7);
    wait_pos(10);
    chk("pt_ones_seg", {25'd0, seg}, 32'h6D);
    chk("pt_ones_dp", {31'd0, dp}, 32'h1);
    wait_pos(18);
    chk("pt_tenths_dig", {29'd0, dig_n}, 32'h6);
    chk("pt_tenths_seg", {25'd0, seg}, 32'h4F);
    chk("pt_tenths_dp", {31'd0, dp}, 32'h0);

    ones = 4'd4;
    wait_pos(0);
    wait_pos(10);
    chk("mid_before", {25'd0, seg}, 32'h66);
    ones = 4'd7;
    wait_pos(12);
    chk("mid_held", {25'd0, seg}, 32'h66);
    wait_pos(10);
    chk("mid_next_frame", {25'd0, seg}, 32'h07);

    tenths = 4'd12;
    wait_pos(0);
    wait_pos(18);
    chk("dash_seg", {25'd0, seg}, 32'h40);
    chk("dash_dig", {29'd0, dig_n}, 32'h6);

    blink = 1'b1;
    wait_pos(0);
    lit_frames = 0;
    for (int k = 0; k < 4; k++) begin
      wait_pos(10);
      if (dig_n != 3'b111) lit_frames++;
    end
    chk("blink_lit_frames", lit_frames, 32'd2);
    blink = 1'b0;
    wait_pos(0);
    wait_pos(10);
    chk("blink_off_lit", {29'd0, dig_n}, 32'h5);

    wait_pos(12);
    rst_n = 1'b0;
    step();
    chk("rst_mid_dig", {29'd0, dig_n}, 32'h7);
    chk("rst_mid_seg", {25'd0, seg}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_restart_fs", {31'd0, frame_start}, 32'h1);
    chk("rst_restart_blank", {29'd0, dig_n}, 32'h7);
    wait_pos(10);
    chk("rst_restart_ones", {25'd0, seg}, 32'h07);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
